// File: rtl/stopwatch_cmd_pkg.sv
// rtl/stopwatch_cmd_pkg.sv - shared event codes, FSM states and command bytes
// Purpose: types and constants shared by the stopwatch command controller files.
// Ports: none (package).
package stopwatch_cmd_pkg;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_RUN   = 3'd1,
    EV_CLEAR = 3'd2,
    EV_MODE  = 3'd3,
    EV_SEC   = 3'd4,
    EV_MIN   = 3'd5,
    EV_HOUR  = 3'd6
  } ev_e;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam logic [7:0] DEF_CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] DEF_CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] DEF_CMD_MODE  = 8'h4D;  // 'M'
  localparam logic [7:0] DEF_CMD_SEC   = 8'h73;  // 's'
  localparam logic [7:0] DEF_CMD_MIN   = 8'h6D;  // 'm'
  localparam logic [7:0] DEF_CMD_HOUR  = 8'h68;  // 'h'

endpackage

// File: rtl/stopwatch_cmd_if.sv
// rtl/stopwatch_cmd_if.sv - button/UART inputs and datapath control outputs
// Purpose: bundles the controller's event inputs and control outputs.
// Ports (signals): i_btn_* button pulses, i_rx_data/i_rx_valid UART byte,
//   o_runstop/o_watch_mode levels, o_clear/o_*up pulses, o_cmd_ack/err/drop status.
// Modports: master drives inputs (source side), slave is the controller.
interface stopwatch_cmd_if;
  logic       i_btn_runstop;
  logic       i_btn_clear;
  logic       i_btn_mode;
  logic       i_btn_secup;
  logic       i_btn_minup;
  logic       i_btn_hourup;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_runstop;
  logic       o_clear;
  logic       o_secup;
  logic       o_minup;
  logic       o_hourup;
  logic       o_watch_mode;
  logic       o_cmd_ack;
  logic       o_cmd_err;
  logic       o_cmd_drop;

  modport master (
    output i_btn_runstop, i_btn_clear, i_btn_mode, i_btn_secup, i_btn_minup,
           i_btn_hourup, i_rx_data, i_rx_valid,
    input  o_runstop, o_clear, o_secup, o_minup, o_hourup, o_watch_mode,
           o_cmd_ack, o_cmd_err, o_cmd_drop
  );

  modport slave (
    input  i_btn_runstop, i_btn_clear, i_btn_mode, i_btn_secup, i_btn_minup,
           i_btn_hourup, i_rx_data, i_rx_valid,
    output o_runstop, o_clear, o_secup, o_minup, o_hourup, o_watch_mode,
           o_cmd_ack, o_cmd_err, o_cmd_drop
  );
endinterface

// File: rtl/stopwatch_cmd_decode.sv
// rtl/stopwatch_cmd_decode.sv - UART command byte to event code decoder
// Purpose: combinational mapping of a received byte to an event code.
// Ports: data_i (8) byte in; ev_o event code; invalid_o high for unknown bytes.
module stopwatch_cmd_decode
  import stopwatch_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_RUN   = DEF_CMD_RUN,
  parameter logic [7:0] CMD_CLEAR = DEF_CMD_CLEAR,
  parameter logic [7:0] CMD_MODE  = DEF_CMD_MODE,
  parameter logic [7:0] CMD_SEC   = DEF_CMD_SEC,
  parameter logic [7:0] CMD_MIN   = DEF_CMD_MIN,
  parameter logic [7:0] CMD_HOUR  = DEF_CMD_HOUR
) (
  input  logic [7:0] data_i,
  output ev_e        ev_o,
  output logic       invalid_o
);

  always_comb begin
    ev_o      = EV_NONE;
    invalid_o = 1'b0;
    if      (data_i == CMD_RUN)   ev_o = EV_RUN;
    else if (data_i == CMD_CLEAR) ev_o = EV_CLEAR;
    else if (data_i == CMD_MODE)  ev_o = EV_MODE;
    else if (data_i == CMD_SEC)   ev_o = EV_SEC;
    else if (data_i == CMD_MIN)   ev_o = EV_MIN;
    else if (data_i == CMD_HOUR)  ev_o = EV_HOUR;
    else                          invalid_o = 1'b1;
  end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// rtl/stopwatch_cmd_ctrl.sv - stopwatch/watch command controller
// Purpose: merges button pulses and UART commands into one event per clock,
//   runs the STOP/RUN/CLEAR FSM and the watch-mode flag, drives datapath controls.
// Ports: clk, rst (sync, active-high); bus (stopwatch_cmd_if.slave) carries
//   all button/UART inputs and registered control/status outputs.
module stopwatch_cmd_ctrl
  import stopwatch_cmd_pkg::*;
#(
  parameter logic [7:0] CMD_RUN   = DEF_CMD_RUN,
  parameter logic [7:0] CMD_CLEAR = DEF_CMD_CLEAR,
  parameter logic [7:0] CMD_MODE  = DEF_CMD_MODE,
  parameter logic [7:0] CMD_SEC   = DEF_CMD_SEC,
  parameter logic [7:0] CMD_MIN   = DEF_CMD_MIN,
  parameter logic [7:0] CMD_HOUR  = DEF_CMD_HOUR
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_cmd_if.slave bus
);

  ev_e    rx_ev;
  logic   rx_invalid;
  logic   new_valid;
  ev_e    btn_ev;
  ev_e    sel_ev;
  logic   sel_uart;
  logic   pend_take;
  logic   new_taken;

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   pend_valid_q, pend_valid_d;
  ev_e    pend_ev_q, pend_ev_d;
  logic   runstop_q, clear_q, secup_q, minup_q, hourup_q;
  logic   secup_d, minup_d, hourup_d;
  logic   ack_q, err_q, drop_q, drop_d;

  stopwatch_cmd_decode #(
    .CMD_RUN  (CMD_RUN),
    .CMD_CLEAR(CMD_CLEAR),
    .CMD_MODE (CMD_MODE),
    .CMD_SEC  (CMD_SEC),
    .CMD_MIN  (CMD_MIN),
    .CMD_HOUR (CMD_HOUR)
  ) u_decode (
    .data_i   (bus.i_rx_data),
    .ev_o     (rx_ev),
    .invalid_o(rx_invalid)
  );

  assign new_valid = bus.i_rx_valid && !rx_invalid;

  // Button priority; losers in the same cycle are simply dropped.
  always_comb begin
    btn_ev = EV_NONE;
    if      (bus.i_btn_mode)    btn_ev = EV_MODE;
    else if (bus.i_btn_clear)   btn_ev = EV_CLEAR;
    else if (bus.i_btn_runstop) btn_ev = EV_RUN;
    else if (bus.i_btn_hourup)  btn_ev = EV_HOUR;
    else if (bus.i_btn_minup)   btn_ev = EV_MIN;
    else if (bus.i_btn_secup)   btn_ev = EV_SEC;
  end

  // Source select and pending slot. A slot drained this cycle may be
  // refilled by the new command in the same cycle.
  always_comb begin
    sel_ev       = EV_NONE;
    sel_uart     = 1'b0;
    pend_take    = 1'b0;
    new_taken    = 1'b0;
    if (btn_ev != EV_NONE) begin
      sel_ev = btn_ev;
    end else if (pend_valid_q) begin
      sel_ev    = pend_ev_q;
      sel_uart  = 1'b1;
      pend_take = 1'b1;
    end else if (new_valid) begin
      sel_ev    = rx_ev;
      sel_uart  = 1'b1;
      new_taken = 1'b1;
    end

    pend_valid_d = pend_valid_q && !pend_take;
    pend_ev_d    = pend_ev_q;
    drop_d       = 1'b0;
    if (new_valid && !new_taken) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_ev_d    = rx_ev;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  // Event application. CLEAR lasts one cycle and swallows whatever is served.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    secup_d  = 1'b0;
    minup_d  = 1'b0;
    hourup_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      state_d = ST_STOP;
    end else begin
      case (sel_ev)
        EV_MODE: begin
          mode_d  = !mode_q;
          state_d = ST_STOP;
        end
        EV_RUN: begin
          if (!mode_q) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
        EV_CLEAR: begin
          if (!mode_q && state_q == ST_STOP) state_d = ST_CLEAR;
        end
        EV_SEC:  secup_d  = mode_q;
        EV_MIN:  minup_d  = mode_q;
        EV_HOUR: hourup_d = mode_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      mode_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_ev_q    <= EV_NONE;
      runstop_q    <= 1'b0;
      clear_q      <= 1'b0;
      secup_q      <= 1'b0;
      minup_q      <= 1'b0;
      hourup_q     <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pend_valid_q <= pend_valid_d;
      pend_ev_q    <= pend_ev_d;
      runstop_q    <= (state_d == ST_RUN);
      clear_q      <= (state_d == ST_CLEAR);
      secup_q      <= secup_d;
      minup_q      <= minup_d;
      hourup_q     <= hourup_d;
      ack_q        <= sel_uart;
      err_q        <= bus.i_rx_valid && rx_invalid;
      drop_q       <= drop_d;
    end
  end

  assign bus.o_runstop    = runstop_q;
  assign bus.o_clear      = clear_q;
  assign bus.o_secup      = secup_q;
  assign bus.o_minup      = minup_q;
  assign bus.o_hourup     = hourup_q;
  assign bus.o_watch_mode = mode_q;
  assign bus.o_cmd_ack    = ack_q;
  assign bus.o_cmd_err    = err_q;
  assign bus.o_cmd_drop   = drop_q;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// tb/tb_stopwatch_cmd_ctrl.sv - directed self-checking bench for stopwatch_cmd_ctrl
module tb_stopwatch_cmd_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  stopwatch_cmd_if bus();

  stopwatch_cmd_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {runstop, clear, secup, minup, hourup, watch_mode, ack, err, drop}
  function automatic logic [8:0] outs();
    return {bus.o_runstop, bus.o_clear, bus.o_secup, bus.o_minup, bus.o_hourup,
            bus.o_watch_mode, bus.o_cmd_ack, bus.o_cmd_err, bus.o_cmd_drop};
  endfunction

  task automatic clr_in();
    bus.i_btn_runstop = 1'b0;
    bus.i_btn_clear   = 1'b0;
    bus.i_btn_mode    = 1'b0;
    bus.i_btn_secup   = 1'b0;
    bus.i_btn_minup   = 1'b0;
    bus.i_btn_hourup  = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_rx_valid    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_in();
    rst = 1'b1;
    step();
    step();
    check_eq("reset_outs", {23'd0, outs()}, 32'd0);
    rst = 1'b0;

    // 1: run/stop toggle
    bus.i_btn_runstop = 1'b1; step(); clr_in();
    check_eq("run_on", {31'd0, bus.o_runstop}, 32'd1);
    step();
    check_eq("run_hold", {31'd0, bus.o_runstop}, 32'd1);
    bus.i_btn_runstop = 1'b1; step(); clr_in();
    check_eq("run_off", {31'd0, bus.o_runstop}, 32'd0);

    // 2: clear from STOP, ignored in RUN
    bus.i_btn_clear = 1'b1; step(); clr_in();
    check_eq("clear_pulse", {23'd0, outs()}, 32'b0_1_0_0_0_0_0_0_0);
    step();
    check_eq("clear_done", {23'd0, outs()}, 32'd0);
    bus.i_btn_runstop = 1'b1; step(); clr_in();
    bus.i_btn_clear = 1'b1; step(); clr_in();
    check_eq("clear_in_run", {23'd0, outs()}, 32'b1_0_0_0_0_0_0_0_0);

    // 3: mode while RUN, 's' in both modes
    bus.i_btn_mode = 1'b1; step(); clr_in();
    check_eq("mode_from_run", {23'd0, outs()}, 32'b0_0_0_0_0_1_0_0_0);
    rx(8'h73); step(); clr_in();
    check_eq("sec_watch", {23'd0, outs()}, 32'b0_0_1_0_0_1_1_0_0);
    step();
    check_eq("sec_one_cycle", {23'd0, outs()}, 32'b0_0_0_0_0_1_0_0_0);
    rx(8'h68); step(); clr_in();
    check_eq("hour_watch", {23'd0, outs()}, 32'b0_0_0_0_1_1_1_0_0);
    bus.i_btn_minup = 1'b1; bus.i_btn_hourup = 1'b1; step(); clr_in();
    check_eq("btn_hour_over_min", {23'd0, outs()}, 32'b0_0_0_0_1_1_0_0_0);
    bus.i_btn_mode = 1'b1; step(); clr_in();
    check_eq("mode_back", {23'd0, outs()}, 32'd0);
    rx(8'h73); step(); clr_in();
    check_eq("sec_stopwatch", {23'd0, outs()}, 32'b0_0_0_0_0_0_1_0_0);

    // 4: button and UART in same cycle
    bus.i_btn_runstop = 1'b1; rx(8'h4D); step(); clr_in();
    check_eq("same_cyc_n1", {23'd0, outs()}, 32'b1_0_0_0_0_0_0_0_0);
    step();
    check_eq("same_cyc_n2", {23'd0, outs()}, 32'b0_0_0_0_0_1_1_0_0);
    bus.i_btn_mode = 1'b1; step(); clr_in();
    check_eq("mode_restore", {23'd0, outs()}, 32'd0);

    // 5: pending fill and drops; secup button is a no-op in stopwatch mode
    bus.i_btn_secup = 1'b1; rx(8'h52); step();
    check_eq("pend_fill", {23'd0, outs()}, 32'd0);
    rx(8'h43); step();
    check_eq("drop_c", {23'd0, outs()}, 32'b0_0_0_0_0_0_0_0_1);
    rx(8'h4D); step(); clr_in();
    check_eq("drop_m", {23'd0, outs()}, 32'b0_0_0_0_0_0_0_0_1);
    step();
    check_eq("pend_served", {23'd0, outs()}, 32'b1_0_0_0_0_0_1_0_0);
    rx(8'h5A); step(); clr_in();
    check_eq("bad_byte", {23'd0, outs()}, 32'b1_0_0_0_0_0_0_1_0);
    step();
    check_eq("bad_byte_clr", {23'd0, outs()}, 32'b1_0_0_0_0_0_0_0_0);

    // 6: reset with a pending command while RUN
    bus.i_btn_secup = 1'b1; rx(8'h52); step(); clr_in();
    check_eq("pend_before_rst", {23'd0, outs()}, 32'b1_0_0_0_0_0_0_0_0);
    rst = 1'b1; step();
    check_eq("rst_mid", {23'd0, outs()}, 32'd0);
    rst = 1'b0; step();
    check_eq("pend_lost", {23'd0, outs()}, 32'd0);
    step();
    check_eq("pend_lost2", {23'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
